// File: rtl/cmdbuilder_if.sv
// Bundles the command request fields and the serial bit stream handshake.
// The master drives the command request and bitready; the slave returns the bit stream and status.
interface cmdbuilder_if;
  logic        start;
  logic [2:0]  cmd_sel;
  logic        dr;
  logic [1:0]  m;
  logic        trext;
  logic [1:0]  sel;
  logic [1:0]  session;
  logic        target;
  logic [3:0]  q;
  logic [2:0]  updn;
  logic [15:0] rn16;
  logic        bitready;
  logic        bitout;
  logic        bitvalid;
  logic        busy;
  logic        done;
  logic        err;

  // Handshake: a bit transfers on every rising edge where bitvalid && bitready.
  // bitout/bitvalid stay stable until that edge; bitready has no effect while bitvalid is low.
  modport master (
    output start, cmd_sel, dr, m, trext, sel, session, target, q, updn, rn16, bitready,
    input  bitout, bitvalid, busy, done, err
  );

  modport slave (
    input  start, cmd_sel, dr, m, trext, sel, session, target, q, updn, rn16, bitready,
    output bitout, bitvalid, busy, done, err
  );
endinterface

// File: rtl/cmdbuilder.sv
// Serialises one reader command per start, MSB first, and appends CRC5 to Query and CRC16 to ReqRN.
// Define CMDTX_CRC16_EN to build in ReqRN and the CRC16 generator; without it, cmd_sel=6 is rejected.
module cmdbuilder (
  input  logic         clk,
  input  logic         reset,
  cmdbuilder_if.slave  bus,
  output logic [1:0]   state_dbg
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_CRC = 2'd2, S_DONE = 2'd3} state_t;
  typedef enum logic [1:0] {CRC_NONE = 2'd0, CRC_5 = 2'd1, CRC_16 = 2'd2} crc_kind_t;

  state_t      state;
  crc_kind_t   crc_kind;
  logic [23:0] shreg;
  logic [4:0]  cnt;
  logic [4:0]  crc5;
  logic [4:0]  crc5_next;
  logic        hs;

  logic        cmd_ok;
  logic [23:0] frame;
  logic [4:0]  frame_len;
  crc_kind_t   frame_crc;

  assign state_dbg = state;
  assign hs        = bus.bitvalid && bus.bitready;
  assign crc5_next = {crc5[3:0], 1'b0} ^ ({5{crc5[4] ^ bus.bitout}} & 5'h09);

`ifdef CMDTX_CRC16_EN
  logic [15:0] crc16;
  logic [15:0] crc16_next;
  assign crc16_next = {crc16[14:0], 1'b0} ^ ({16{crc16[15] ^ bus.bitout}} & 16'h1021);
`endif

  // Payload is left-aligned in 24 bits so the MSB always leaves first.
  always_comb begin
    cmd_ok    = 1'b1;
    frame     = '0;
    frame_len = '0;
    frame_crc = CRC_NONE;
    case (bus.cmd_sel)
      3'd0: begin
        frame     = {2'b00, bus.session, 20'd0};
        frame_len = 5'd4;
      end
      3'd1: begin
        frame     = {2'b01, bus.rn16, 6'd0};
        frame_len = 5'd18;
      end
      3'd2: begin
        frame     = {4'b1000, bus.dr, bus.m, bus.trext, bus.sel, bus.session,
                     bus.target, bus.q, 7'd0};
        frame_len = 5'd17;
        frame_crc = CRC_5;
      end
      3'd3: begin
        frame     = {4'b1001, bus.session, bus.updn, 15'd0};
        frame_len = 5'd9;
      end
      3'd5: begin
        frame     = {8'b11000000, 16'd0};
        frame_len = 5'd8;
      end
`ifdef CMDTX_CRC16_EN
      3'd6: begin
        frame     = {8'b11000001, bus.rn16};
        frame_len = 5'd24;
        frame_crc = CRC_16;
      end
`endif
      default: cmd_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      crc_kind     <= CRC_NONE;
      shreg        <= '0;
      cnt          <= '0;
      crc5         <= '0;
`ifdef CMDTX_CRC16_EN
      crc16        <= '0;
`endif
      bus.bitout   <= 1'b0;
      bus.bitvalid <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (cmd_ok) begin
              bus.bitout   <= frame[23];
              shreg        <= {frame[22:0], 1'b0};
              cnt          <= frame_len;
              crc_kind     <= frame_crc;
              crc5         <= 5'h09;
`ifdef CMDTX_CRC16_EN
              crc16        <= 16'hFFFF;
`endif
              bus.bitvalid <= 1'b1;
              bus.busy     <= 1'b1;
              state        <= S_SEND;
            end else begin
              bus.err <= 1'b1;
            end
          end
        end
        S_SEND: begin
          if (hs) begin
            crc5 <= crc5_next;
`ifdef CMDTX_CRC16_EN
            crc16 <= crc16_next;
`endif
            if (cnt == 5'd1) begin
              // Last payload bit: the first CRC bit follows on the very next cycle.
              case (crc_kind)
                CRC_5: begin
                  bus.bitout <= crc5_next[4];
                  shreg      <= {crc5_next[3:0], 20'd0};
                  cnt        <= 5'd5;
                  state      <= S_CRC;
                end
`ifdef CMDTX_CRC16_EN
                CRC_16: begin
                  bus.bitout <= ~crc16_next[15];
                  shreg      <= {~crc16_next[14:0], 9'd0};
                  cnt        <= 5'd16;
                  state      <= S_CRC;
                end
`endif
                default: begin
                  bus.bitout   <= 1'b0;
                  bus.bitvalid <= 1'b0;
                  bus.done     <= 1'b1;
                  state        <= S_DONE;
                end
              endcase
            end else begin
              bus.bitout <= shreg[23];
              shreg      <= {shreg[22:0], 1'b0};
              cnt        <= cnt - 5'd1;
            end
          end
        end
        S_CRC: begin
          if (hs) begin
            if (cnt == 5'd1) begin
              bus.bitout   <= 1'b0;
              bus.bitvalid <= 1'b0;
              bus.done     <= 1'b1;
              state        <= S_DONE;
            end else begin
              bus.bitout <= shreg[23];
              shreg      <= {shreg[22:0], 1'b0};
              cnt        <= cnt - 5'd1;
            end
          end
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/cmdbuilder.md
CMDBUILDER -- requirements
Module: cmdbuilder

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high.
REQ-003 SHALL have: start  in  1  request to build/send one reader command; sampled in IDLE only.
REQ-004 SHALL have: cmd_sel  in  3  0=QueryRep, 1=Ack, 2=Query, 3=QueryAdj, 5=Nack, 6=ReqRN; 4,7 invalid.
REQ-005 SHALL have: dr  in  1; m  in  2; trext  in  1; sel  in  2; session  in  2; target  in  1; q  in  4; updn  in  3  (field values, latched on accepted start).
REQ-006 SHALL have: rn16  in  16  handle for Ack/ReqRN, latched on accepted start.
REQ-007 SHALL have: bitready  in  1  downstream (PIE encoder) consumes bitout when bitvalid&&bitready.
REQ-008 SHALL have: bitout  out  1  current bit, MSB-first; bitvalid  out  1  bitout valid.
REQ-009 SHALL have: busy  out  1; done  out  1  one-cycle pulse after last bit consumed; err  out  1  one-cycle pulse on rejected start.

Function
REQ-010 SHALL implement FSM IDLE -> SEND -> (CRC, Query/ReqRN only) -> DONE -> IDLE.
REQ-011 IDLE: start with valid cmd_sel SHALL latch all fields, load bit counter, enter SEND; busy=1 and bitvalid=1 from next cycle.
REQ-012 Frames (bits, MSB first) SHALL be: QueryRep 00+session (4); Ack 01+rn16 (18); Query 1000+dr+m+trext+sel+session+target+q (17) +CRC5 (22 total); QueryAdj 1001+session+updn (9); Nack 11000000 (8); ReqRN 11000001+rn16 (24) +CRC16 (40 total).
REQ-013 bitout/bitvalid SHALL hold stable while bitready=0; advance exactly one bit per handshake cycle; no bubble between payload and CRC bits.
REQ-014 CRC5 SHALL be x^5+x^3+1, preset 5'b01001, updated per payload bit on handshake, sent unmodified MSB first.
REQ-015 CRC16 SHALL be CCITT 0x1021, preset 16'hFFFF, updated per payload bit on handshake, sent ones-complemented MSB first.
REQ-016 After last-bit handshake SHALL enter DONE: bitvalid=0, done=1 for one cycle, busy=0 next cycle, return IDLE.
REQ-017 start while not IDLE SHALL be ignored (no err, latched fields unchanged).
REQ-018 start in IDLE with invalid cmd_sel SHALL stay IDLE, pulse err one cycle, bitvalid remains 0.
REQ-019 start asserted in the DONE cycle SHALL be ignored; accepted only from IDLE the following cycle.
REQ-020 bitready asserted while bitvalid=0 SHALL have no effect.

Reset
REQ-021 reset SHALL force IDLE; bitout=0, bitvalid=0, busy=0, done=0, err=0, bit counter and CRC registers cleared.
REQ-022 reset mid-frame SHALL abandon the frame; no done pulse; next start after reset deassertion builds a fresh frame.

Configuration
REQ-023 Macro CMDTX_CRC16_EN defined: ReqRN (cmd_sel=6) and CRC16 generator compiled in per REQ-012/015.
REQ-024 Macro CMDTX_CRC16_EN undefined: CRC16 logic absent; cmd_sel=6 treated as invalid per REQ-018.

Verification
REQ-025 Query, all fields 0, bitready=1 -> 22 bits 1000000000000000010000 (CRC5=10000), done pulse after 22nd handshake.
REQ-026 Ack rn16=16'hA5A5 -> 18 bits 01 1010010110100101, no CRC, done after 18 handshakes.
REQ-027 QueryRep session=2'b10, bitready low 3 cycles after 2nd bit -> 0010, bitout/bitvalid frozen during stall, total 4 handshakes.
REQ-028 ReqRN rn16=16'h0000 (CMDTX_CRC16_EN) -> 40 bits; feeding all 40 into CRC16 preset FFFF gives residue 16'h1D0F; without macro -> err pulse, no bits.
REQ-029 cmd_sel=4 start -> err one cycle, busy=0; Nack started then second start mid-frame -> ignored, 11000000 sent unchanged.
REQ-030 Query started, reset asserted after 10th bit -> all outputs 0 next cycle, no done; subsequent Nack -> 11000000 correct.
